// File: rtl/oops_structs.sv
// -----------------------------------------------------------------------------
// oops_structs
// Shared types for the memory arbiter that sits between the CPU instruction /
// data ports and the single downstream memory port.
//   arb_state_t : arbiter FSM state (IDLE, BUSY, RESP)
//   arb_src_t   : which CPU port owns the transaction in flight (INST, DATA)
// -----------------------------------------------------------------------------
package oops_structs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_src_t;

  localparam int MBE_WIDTH = 4;

  // Width of a counter that must hold 0..limit; never narrower than 1 bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates the CPU instruction-read port and data read/write port onto one
// memory port. Data requests normally win; an instruction request that has
// waited through STARVE_LIMIT data grants wins the next arbitration.
// One transaction is in flight at a time: IDLE (arbitrate) -> BUSY (wait for
// mem_resp) -> RESP (one-cycle response pulse to the owning port) -> IDLE.
//
// Ports
//   clk, rst                    clock, asynchronous active-low reset
//   inst_read, inst_addr        instruction read request (held until inst_resp)
//   inst_resp, inst_rdata       instruction completion pulse and read word
//   data_read, data_write       data request (held until data_resp)
//   data_mbe, data_addr,
//   data_wdata                  data byte enables, address, store data
//   data_resp, data_rdata       data completion pulse and load word
//   mem_read, mem_write,
//   mem_mbe, mem_addr,
//   mem_wdata                   downstream request (held until mem_resp)
//   mem_resp, mem_rdata         downstream completion and read data
// -----------------------------------------------------------------------------
module mem_arbiter
  import oops_structs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  inst_read,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_resp,
  output logic [DATA_WIDTH-1:0] inst_rdata,

  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [MBE_WIDTH-1:0]  data_mbe,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_resp,
  output logic [DATA_WIDTH-1:0] data_rdata,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MBE_WIDTH-1:0]  mem_mbe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int                CNT_W   = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t            state_q;
  arb_src_t              src_q;
  logic [CNT_W-1:0]      starve_cnt_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [MBE_WIDTH-1:0]  mem_mbe_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  inst_resp_q;
  logic                  data_resp_q;

  // Arbitration decision, only acted on in IDLE.
  logic has_data;
  logic inst_starved;
  logic grant_inst;
  logic grant_data;

  assign has_data     = data_read | data_write;
  assign inst_starved = (starve_cnt_q == CNT_MAX);
  assign grant_inst   = inst_read & (~has_data | inst_starved);
  assign grant_data   = has_data & ~grant_inst;

  // NOTE: every register here, including the datapath, is reset: the outputs
  // must read 0 while rst is low, and all state uses non-blocking assignment
  // so each edge sees the previous cycle's values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_q        <= INST;
      starve_cnt_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_mbe_q    <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      inst_resp_q  <= 1'b0;
      data_resp_q  <= 1'b0;
    end else begin
      // Response strobes are single-cycle unless set again below.
      inst_resp_q <= 1'b0;
      data_resp_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_inst) begin
            state_q      <= BUSY;
            src_q        <= INST;
            mem_read_q   <= 1'b1;
            mem_write_q  <= 1'b0;
            mem_mbe_q    <= '0;
            mem_addr_q   <= inst_addr;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
          end else if (grant_data) begin
            state_q     <= BUSY;
            src_q       <= DATA;
            // A simultaneous read+write is treated as a write.
            mem_read_q  <= ~data_write;
            mem_write_q <= data_write;
            mem_mbe_q   <= data_mbe;
            mem_addr_q  <= data_addr;
            mem_wdata_q <= data_wdata;
            // Count only grants that made a waiting instruction wait longer.
            if (inst_read && !inst_starved) begin
              starve_cnt_q <= starve_cnt_q + 1'b1;
            end
          end
        end

        BUSY: begin
          // CPU inputs are not looked at here; the captured request is held.
          if (mem_resp) begin
            state_q     <= RESP;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rdata_q     <= mem_rdata;
            inst_resp_q <= (src_q == INST);
            data_resp_q <= (src_q == DATA);
          end
        end

        RESP: begin
          // Requests still held here are ignored until the next IDLE.
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_mbe    = mem_mbe_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign inst_resp  = inst_resp_q;
  assign data_resp  = data_resp_q;
  assign inst_rdata = rdata_q;
  assign data_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import oops_structs::*;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_resp;
  logic [31:0] data_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_mbe;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  int tests_run;
  int tests_failed;

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_read (inst_read),
    .inst_addr (inst_addr),
    .inst_resp (inst_resp),
    .inst_rdata(inst_rdata),
    .data_read (data_read),
    .data_write(data_write),
    .data_mbe  (data_mbe),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_resp (data_resp),
    .data_rdata(data_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_mbe   (mem_mbe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_resp  (mem_resp),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst = 1'b0;
    inst_read = 0; inst_addr = '0; data_read = 0; data_write = 0;
    data_mbe = '0; data_addr = '0; data_wdata = '0; mem_resp = 0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    tests_run++; if ({mem_read, mem_write, inst_resp, data_resp} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_strobes: got %b expected 0000", {mem_read, mem_write, inst_resp, data_resp}); end
    tests_run++; if ({mem_addr, mem_wdata, mem_mbe} !== 68'h0) begin
      tests_failed++; $display("FAIL reset_mem_fields: got %h expected 0", {mem_addr, mem_wdata, mem_mbe}); end
    tests_run++; if ({inst_rdata, data_rdata} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h expected 0", {inst_rdata, data_rdata}); end
    tests_run++; if (dut.state_q !== IDLE || dut.starve_cnt_q !== 3'd0) begin
      tests_failed++; $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", dut.state_q, dut.starve_cnt_q); end
    // A request during reset must not be granted.
    inst_read = 1; inst_addr = 32'h44;
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL reset_no_grant: got %b expected 0", mem_read); end
    inst_read = 0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_inst_read();
    inst_read = 1; inst_addr = 32'h60;
    @(negedge clk);  // grant edge passed: request-to-mem latency of one cycle
    tests_run++; if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h60) begin
      tests_failed++; $display("FAIL inst_req: got rd %b wr %b addr %h expected 1 0 00000060", mem_read, mem_write, mem_addr); end
    inst_addr = 32'h99;  // must be ignored while BUSY
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b1 || mem_addr !== 32'h60 || inst_resp !== 1'b0) begin
      tests_failed++; $display("FAIL inst_hold: got rd %b addr %h resp %b expected 1 00000060 0", mem_read, mem_addr, inst_resp); end
    mem_resp = 1; mem_rdata = 32'h00000013;
    @(negedge clk);
    mem_resp = 0;
    tests_run++; if (inst_resp !== 1'b1 || inst_rdata !== 32'h13 || data_resp !== 1'b0) begin
      tests_failed++; $display("FAIL inst_resp: got resp %b rdata %h dresp %b expected 1 00000013 0", inst_resp, inst_rdata, data_resp); end
    tests_run++; if (data_rdata !== 32'h13 || mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL inst_resp_side: got drdata %h rd %b expected 00000013 0", data_rdata, mem_read); end
    inst_read = 0;
    @(negedge clk);
    tests_run++; if (inst_resp !== 1'b0 || mem_read !== 1'b0 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL inst_single_pulse: got resp %b rd %b state %0d expected 0 0 0", inst_resp, mem_read, dut.state_q); end
  endtask

  task automatic test_write();
    data_write = 1; data_addr = 32'h100; data_mbe = 4'b0011; data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++; if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h100) begin
      tests_failed++; $display("FAIL wr_req: got rd %b wr %b addr %h expected 0 1 00000100", mem_read, mem_write, mem_addr); end
    tests_run++; if (mem_mbe !== 4'b0011 || mem_wdata !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL wr_fields: got mbe %b wdata %h expected 0011 deadbeef", mem_mbe, mem_wdata); end
    mem_resp = 1; mem_rdata = 32'h11110000;
    @(negedge clk);
    mem_resp = 0;
    tests_run++; if (data_resp !== 1'b1 || inst_resp !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++; $display("FAIL wr_resp: got dresp %b iresp %b wr %b expected 1 0 0", data_resp, inst_resp, mem_write); end
    data_write = 0;
    @(negedge clk);
    tests_run++; if (data_resp !== 1'b0 || mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL wr_single_pulse: got dresp %b rd %b expected 0 0", data_resp, mem_read); end
  endtask

  task automatic test_rw_both();
    data_read = 1; data_write = 1; data_addr = 32'h120; data_mbe = 4'b1111; data_wdata = 32'h0BADF00D;
    @(negedge clk);
    tests_run++; if ({mem_read, mem_write} !== 2'b01 || mem_wdata !== 32'h0BADF00D) begin
      tests_failed++; $display("FAIL rw_both_as_write: got rd %b wr %b wdata %h expected 0 1 0badf00d", mem_read, mem_write, mem_wdata); end
    mem_resp = 1; mem_rdata = 32'h0;
    @(negedge clk);
    mem_resp = 0; data_read = 0; data_write = 0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    inst_read = 1; inst_addr = 32'h200; data_read = 1; data_addr = 32'h300;
    tests_run++; if (dut.starve_cnt_q !== 3'd0) begin
      tests_failed++; $display("FAIL sim_cnt_start: got %0d expected 0", dut.starve_cnt_q); end
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b1 || mem_addr !== 32'h300 || dut.starve_cnt_q !== 3'd1) begin
      tests_failed++; $display("FAIL sim_data_first: got rd %b addr %h cnt %0d expected 1 00000300 1", mem_read, mem_addr, dut.starve_cnt_q); end
    mem_resp = 1; mem_rdata = 32'hAAAA0001;
    @(negedge clk);
    mem_resp = 0;
    tests_run++; if (data_resp !== 1'b1 || inst_resp !== 1'b0 || data_rdata !== 32'hAAAA0001) begin
      tests_failed++; $display("FAIL sim_data_resp: got dresp %b iresp %b rdata %h expected 1 0 aaaa0001", data_resp, inst_resp, data_rdata); end
    data_read = 0;
    @(negedge clk);  // IDLE: inst still waiting
    tests_run++; if (mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL sim_idle_gap: got rd %b expected 0", mem_read); end
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b1 || mem_addr !== 32'h200 || dut.starve_cnt_q !== 3'd0) begin
      tests_failed++; $display("FAIL sim_inst_second: got rd %b addr %h cnt %0d expected 1 00000200 0", mem_read, mem_addr, dut.starve_cnt_q); end
    mem_resp = 1; mem_rdata = 32'hBBBB0002;
    @(negedge clk);
    mem_resp = 0;
    tests_run++; if (inst_resp !== 1'b1 || data_resp !== 1'b0 || inst_rdata !== 32'hBBBB0002) begin
      tests_failed++; $display("FAIL sim_inst_resp: got iresp %b dresp %b rdata %h expected 1 0 bbbb0002", inst_resp, data_resp, inst_rdata); end
    inst_read = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [6];
    logic [2:0]  exp_cnt  [6];
    logic        exp_inst [6];
    int di;
    exp_addr = '{32'h500, 32'h504, 32'h508, 32'h50C, 32'h400, 32'h510};
    exp_cnt  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    exp_inst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    di = 0;
    inst_read = 1; inst_addr = 32'h400; data_read = 1; data_addr = 32'h500;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      tests_run++; if (mem_read !== 1'b1 || mem_addr !== exp_addr[t] || dut.starve_cnt_q !== exp_cnt[t]) begin
        tests_failed++; $display("FAIL starve_grant_%0d: got rd %b addr %h cnt %0d expected 1 %h %0d", t, mem_read, mem_addr, dut.starve_cnt_q, exp_addr[t], exp_cnt[t]); end
      mem_resp = 1; mem_rdata = 32'hC0DE0000 + t;
      @(negedge clk);
      mem_resp = 0;
      tests_run++; if (inst_resp !== exp_inst[t] || data_resp !== !exp_inst[t]) begin
        tests_failed++; $display("FAIL starve_resp_%0d: got iresp %b dresp %b expected %b %b", t, inst_resp, data_resp, exp_inst[t], !exp_inst[t]); end
      if (exp_inst[t]) inst_read = 0;
      else begin
        di++;
        if (di < 5) data_addr = 32'h500 + 32'(4 * di);
        else data_read = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_busy();
    inst_read = 1; inst_addr = 32'h80;
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b1) begin
      tests_failed++; $display("FAIL rstbusy_req: got rd %b expected 1", mem_read); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++; if (mem_read !== 1'b0 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL rstbusy_async: got rd %b state %0d expected 0 0", mem_read, dut.state_q); end
    mem_resp = 1; mem_rdata = 32'h5A5A5A5A;
    @(negedge clk); @(negedge clk);
    tests_run++; if (inst_resp !== 1'b0 || data_resp !== 1'b0 || mem_read !== 1'b0) begin
      tests_failed++; $display("FAIL rstbusy_no_resp: got iresp %b dresp %b rd %b expected 0 0 0", inst_resp, data_resp, mem_read); end
    mem_resp = 0;
    rst = 1'b1;  // inst_read still held: first grant on the next rising edge
    @(negedge clk);
    tests_run++; if (mem_read !== 1'b1 || mem_addr !== 32'h80) begin
      tests_failed++; $display("FAIL rstbusy_regrant: got rd %b addr %h expected 1 00000080", mem_read, mem_addr); end
    mem_resp = 1; mem_rdata = 32'hCAFE0080;
    @(negedge clk);
    mem_resp = 0;
    tests_run++; if (inst_resp !== 1'b1 || inst_rdata !== 32'hCAFE0080) begin
      tests_failed++; $display("FAIL rstbusy_recover: got iresp %b rdata %h expected 1 cafe0080", inst_resp, inst_rdata); end
    inst_read = 0;
    @(negedge clk);
  endtask

  task automatic test_stray_resp();
    mem_resp = 1; mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (inst_resp !== 1'b0 || data_resp !== 1'b0 || dut.state_q !== IDLE) begin
      tests_failed++; $display("FAIL stray_resp: got iresp %b dresp %b state %0d expected 0 0 0", inst_resp, data_resp, dut.state_q); end
    tests_run++; if (inst_rdata !== 32'hCAFE0080) begin
      tests_failed++; $display("FAIL stray_rdata: got %h expected cafe0080", inst_rdata); end
    mem_resp = 0;
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_inst_read();
    test_write();
    test_rw_both();
    test_simultaneous();
    test_starvation();
    test_reset_busy();
    test_stray_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
